// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment codes and the
// BCD-to-segment lookup used by the digit decoder.
package seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment (common anode).
  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_LUT [0:9] = '{
    7'b0000001,
    7'b1001111,
    7'b0010010,
    7'b0000110,
    7'b1001100,
    7'b0100100,
    7'b0100000,
    7'b0001111,
    7'b0000000,
    7'b0000100
  };

  function automatic logic bcd_valid(input logic [3:0] bcd);
    return (bcd <= 4'd9);
  endfunction

  function automatic seg_t seg_of(input logic [3:0] bcd);
    if (!bcd_valid(bcd)) begin
      return SEG_BLANK;
    end
    return SEG_LUT[bcd];
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD digit to active-low seven-segment pattern; codes above 9
// come out blank.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  assign seg = seg_of(bcd);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment driver with a tear-free
// double-buffered frame. Optional leading-zero blanking: define SEG_LZB_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int CLK_DIV    = 100000,
  localparam int CNT_W      = $clog2(CLK_DIV),
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    pending,
  output logic                    frame_start,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        prescaler;
  logic [IDX_W-1:0]        idx;
  logic                    tc;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] pend_bcd;
  logic [NUM_DIGITS-1:0]   pend_dp;

  logic [3:0]              cur_bcd;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [SEG_W-1:0]        dec_seg;
  logic [NUM_DIGITS-1:0]   lzb_mask;

  assign tc       = (prescaler == CNT_LAST);
  assign boundary = tc && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (tc) begin
      prescaler <= '0;
      idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      prescaler <= prescaler + CNT_W'(1);
    end
  end

  // A load landing on the boundary bypasses the pending buffer so it is not
  // delayed by a whole extra frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_bcd <= '0;
      disp_dp  <= '0;
      pend_bcd <= '0;
      pend_dp  <= '0;
      pending  <= 1'b0;
    end else if (load && boundary) begin
      disp_bcd <= bcd_in;
      disp_dp  <= dp_in;
      pending  <= 1'b0;
    end else if (load) begin
      pend_bcd <= bcd_in;
      pend_dp  <= dp_in;
      pending  <= 1'b1;
    end else if (boundary && pending) begin
      disp_bcd <= pend_bcd;
      disp_dp  <= pend_dp;
      pending  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
    end
  end

  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_bcd   = disp_bcd[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_blank = lzb_mask[k];
      end
    end
  end

`ifdef SEG_LZB_EN
  logic lzb_run;

  // Walk down from the most significant digit; a nonzero digit or a lit
  // decimal point ends the run of blanked zeros. Digit 0 always shows.
  always_comb begin
    lzb_mask = '0;
    lzb_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (lzb_run && (disp_bcd[4*k +: 4] == 4'd0) && !disp_dp[k]) begin
        lzb_mask[k] = 1'b1;
      end else begin
        lzb_run = 1'b0;
      end
    end
  end
`else
  assign lzb_mask = '0;
`endif

  seg_digit_decode u_decode (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= cur_blank ? SEG_BLANK : dec_seg;
      dp  <= ~(cur_dp && bcd_valid(cur_bcd));
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule
